// File: rtl/gomoku_pkg.sv
// Shared constants and types for the gomoku board logic.
// Flicker half-periods are in 1 MHz timebase cycles.
package gomoku_pkg;

    localparam int GOMOKU_FLICKER_SLOW_HALF = 1000;
    localparam int GOMOKU_FLICKER_FAST_HALF = 250;

    typedef struct packed {
        logic lvl;    // flicker clock level
        logic pulse;  // high for the cycle that follows a toggle
    } flicker_out_t;

endpackage

// File: rtl/gomoku_flicker_div.sv
// One flicker divider. A counter runs modulo HALF and toggles a 50 % clock on each wrap.
// The divider also emits a one-cycle pulse with each toggle.
module gomoku_flicker_div
    import gomoku_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         wrap_ok,
    output flicker_out_t out
);

    localparam int             W    = $clog2(HALF);
    localparam logic [W-1:0]   LAST = W'(HALF - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         lvl_q, lvl_d;
    logic         pulse_q, pulse_d;

    // The first step after restart only moves the count off zero, so a wrap
    // can never be due before the synchronizer's second stage is set.
    always_comb begin
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        pulse_d = 1'b0;
        if (step && cnt_q == LAST && wrap_ok) begin
            cnt_d   = '0;
            lvl_d   = ~lvl_q;
            pulse_d = 1'b1;
        end else if (step && cnt_q != LAST) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: the level is preset on the async reset so a strobe lights the LED before any clk edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            lvl_q   <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
        end
    end

    assign out.lvl   = lvl_q;
    assign out.pulse = pulse_q;

endmodule

// File: rtl/gomoku_rst_sync.sv
// Two-flop reset synchronizer. Assertion is asynchronous and release is synchronous.
// arm is the first stage and rel is the fully synchronized release.
module gomoku_rst_sync (
    input  logic clk,
    input  logic rst_async,
    output logic arm,
    output logic rel
);

    logic arm_q, arm_d;
    logic rel_q, rel_d;

    always_comb begin
        arm_d = 1'b1;
        rel_d = arm_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            arm_q <= 1'b0;
            rel_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
            rel_q <= rel_d;
        end
    end

    assign arm = arm_q;
    assign rel = rel_q;

endmodule

// File: rtl/gomoku_flicker_clkgen.sv
// Slow and fast LED flicker clocks. Each led_flicker_clk_rst strobe restarts both
// clocks high and in phase.
module gomoku_flicker_clkgen
    import gomoku_pkg::*;
#(
    parameter int SLOW_HALF = GOMOKU_FLICKER_SLOW_HALF,
    parameter int FAST_HALF = GOMOKU_FLICKER_FAST_HALF
) (
    input  logic clk,
    input  logic led_flicker_clk_rst,
    input  logic en,
    output logic led_flicker_clk_slow,
    output logic led_flicker_clk_fast,
    output logic slow_edge,
    output logic fast_edge
);

    if (SLOW_HALF < 2 || FAST_HALF < 2) begin : g_bad_half
        $error("gomoku_flicker_clkgen: SLOW_HALF and FAST_HALF must both be >= 2");
    end

    logic         sync_arm;
    logic         sync_rel;
    logic         step;
    flicker_out_t slow_out;
    flicker_out_t fast_out;

    gomoku_rst_sync u_rst_sync (
        .clk       (clk),
        .rst_async (led_flicker_clk_rst),
        .arm       (sync_arm),
        .rel       (sync_rel)
    );

    // Counting edge E1 is the 2nd clk edge after release, when the first stage is already set.
    assign step = en & sync_arm;

    gomoku_flicker_div #(.HALF(SLOW_HALF)) u_slow (
        .clk     (clk),
        .rst     (led_flicker_clk_rst),
        .step    (step),
        .wrap_ok (sync_rel),
        .out     (slow_out)
    );

    gomoku_flicker_div #(.HALF(FAST_HALF)) u_fast (
        .clk     (clk),
        .rst     (led_flicker_clk_rst),
        .step    (step),
        .wrap_ok (sync_rel),
        .out     (fast_out)
    );

    assign led_flicker_clk_slow = slow_out.lvl;
    assign led_flicker_clk_fast = fast_out.lvl;
    assign slow_edge            = slow_out.pulse;
    assign fast_edge            = fast_out.pulse;

endmodule
